// File: rtl/fp_pkg.sv
// Shared fp32 types and helpers for converting block-floating-point vectors to fp32.
// Holds the fp32 field layout, the unpacker FSM encoding and a leading-one finder.
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MANT_W = 23;
  localparam int EXP_BIAS = 127;
  localparam logic [7:0] FP32_INF_EXP = 8'hFF;
  localparam int LZC_W = 128;

  typedef struct packed {
    logic              sign;
    logic [7:0]        exp;
    logic [MANT_W-1:0] mant;
  } fp32_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } unpack_state_t;

  // Position of the most significant set bit; returns 0 for an all-zero input.
  function automatic logic [7:0] lead_one_pos(input logic [LZC_W-1:0] v);
    logic [7:0] pos;
    pos = 8'd0;
    for (int i = 0; i < LZC_W; i++) begin
      if (v[i]) begin
        pos = 8'(i);
      end else begin
        pos = pos;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/fixed_to_fp32_elem.sv
// Combinational converter: one signed fixed-point mantissa with an unbiased exponent
// becomes an fp32 word, truncating the fraction and flushing underflow to signed zero.
module fixed_to_fp32_elem
  import fp_pkg::*;
#(
  parameter int DATA_WIDTH  = 48,
  parameter int FIXED_POINT = 46,
  parameter int EXP_W       = 8
) (
  input  logic [DATA_WIDTH-1:0] mant,
  input  logic [EXP_W-1:0]      exp,
  output fp32_t                 fp
);

  localparam int EW = EXP_W + $clog2(DATA_WIDTH) + 2;
  localparam logic signed [EW-1:0] E_BIAS = EW'(EXP_BIAS);
  localparam logic signed [EW-1:0] E_INF  = EW'(int'(FP32_INF_EXP));
  localparam logic signed [EW-1:0] E_FP   = EW'(FIXED_POINT);

  logic                   sign_s;
  logic [DATA_WIDTH-1:0]  mag_s;
  logic [DATA_WIDTH-1:0]  norm_s;
  logic [7:0]             lead_s;
  logic [7:0]             shamt_s;
  logic signed [EW-1:0]   e_s;
  logic signed [EW-1:0]   biased_s;
  logic [MANT_W-1:0]      frac_s;

  // Magnitude, leading-one normalisation and exponent arithmetic.
  always_comb begin
    sign_s = mant[DATA_WIDTH-1];
    if (sign_s) begin
      // -2^(W-1) negates to itself, which is the correct unsigned magnitude.
      mag_s = -mant;
    end else begin
      mag_s = mant;
    end
    lead_s   = lead_one_pos(LZC_W'(mag_s));
    shamt_s  = 8'(DATA_WIDTH - 1) - lead_s;
    norm_s   = mag_s << shamt_s;
    frac_s   = MANT_W'(norm_s >> (DATA_WIDTH - 1 - MANT_W));
    e_s      = EW'($signed(exp)) + EW'($signed({1'b0, lead_s})) - E_FP;
    biased_s = e_s + E_BIAS;
  end

  // Classify the result: zero, overflow to infinity, underflow flush, or normal.
  always_comb begin
    fp = '0;
    if (mag_s == '0) begin
      fp = '0;
    end else if (biased_s >= E_INF) begin
      fp.sign = sign_s;
      fp.exp  = FP32_INF_EXP;
      fp.mant = '0;
    end else if (biased_s <= EW'(0)) begin
      fp.sign = sign_s;
      fp.exp  = 8'h00;
      fp.mant = '0;
    end else begin
      fp.sign = sign_s;
      fp.exp  = biased_s[7:0];
      fp.mant = frac_s;
    end
  end

endmodule

// File: rtl/bfp_to_fp32_unpacker.sv
// Block-floating-point vector to N fp32 words, one element per cycle through a shared
// converter; the whole result vector is presented at once under a valid/ready handshake.
module bfp_to_fp32_unpacker
  import fp_pkg::*;
#(
  parameter int N           = 8,
  parameter int DATA_WIDTH  = 48,
  parameter int FIXED_POINT = 46,
  parameter int EXP_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXP_W-1:0]      in_exp,
  input  logic [DATA_WIDTH-1:0] in_mant [0:N-1],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_fp   [0:N-1]
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  unpack_state_t         state_r;
  unpack_state_t         state_next_s;
  logic [IDX_W-1:0]      idx_r;
  logic                  last_s;
  logic                  in_ready_r;
  logic                  out_valid_r;
  logic [EXP_W-1:0]      exp_r;
  logic [DATA_WIDTH-1:0] mant_r [0:N-1];
  logic [31:0]           fp_r   [0:N-1];
  fp32_t                 elem_fp_s;

  fixed_to_fp32_elem #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIXED_POINT(FIXED_POINT),
    .EXP_W      (EXP_W)
  ) u_elem (
    .mant(mant_r[idx_r]),
    .exp (exp_r),
    .fp  (elem_fp_s)
  );

  assign last_s = (idx_r == IDX_W'(N - 1));

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_next_s = CONV;
        end else begin
          state_next_s = IDLE;
        end
      end
      CONV: begin
        if (last_s) begin
          state_next_s = HOLD;
        end else begin
          state_next_s = CONV;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = HOLD;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register; handshake flags are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      in_ready_r  <= (state_next_s == IDLE);
      out_valid_r <= (state_next_s == HOLD);
    end
  end

  // Capture registers, element index and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r <= '0;
      exp_r <= '0;
      for (int i = 0; i < N; i++) begin
        mant_r[i] <= '0;
        fp_r[i]   <= 32'h0000_0000;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            idx_r <= '0;
            exp_r <= in_exp;
            for (int i = 0; i < N; i++) begin
              mant_r[i] <= in_mant[i];
            end
          end
        end
        CONV: begin
          fp_r[idx_r] <= elem_fp_s;
          if (last_s) begin
            idx_r <= '0;
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        HOLD: begin
          idx_r <= idx_r;
        end
        default: begin
          idx_r <= '0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_fp    = fp_r;

endmodule
